move_round_arbiter: RTL and testbench

- Sequences one movement round per game tick for the hero and two enemies on the shared 16x16 grid.
- Each requester gets one slot, in fixed order: hero, enemy 0, enemy 1.
- In each slot the block checks the move target against the grid bounds, the shared map ROM (wall lookup) and the current positions of the other entities, then commits the move or rejects it.
- It sits between the input/AI direction sources and the renderer. It is the only writer of entity positions.

---
 rtl/move_round_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_move_round_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_round_arbiter.sv
// One movement round per game tick: hero, enemy 0 and enemy 1 each get a
// CALC/WAIT/COMMIT slot that checks bounds, map walls and occupancy before moving.
module move_round_arbiter #(
    parameter logic [3:0] HERO_X0 = 4'd0,
    parameter logic [3:0] HERO_Y0 = 4'd0,
    parameter logic [3:0] E0_X0   = 4'd15,
    parameter logic [3:0] E0_Y0   = 4'd15,
    parameter logic [3:0] E1_X0   = 4'd15,
    parameter logic [3:0] E1_Y0   = 4'd0
) (
    input  logic       clk_1,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] hero_dir,
    input  logic [3:0] e0_dir,
    input  logic [3:0] e1_dir,
    output logic [7:0] map_addr,
    input  logic       map_wall,
    output logic [3:0] position_hero_x,
    output logic [3:0] position_hero_y,
    output logic [3:0] e0_x,
    output logic [3:0] e0_y,
    output logic [3:0] e1_x,
    output logic [3:0] e1_y,
    output logic       busy,
    output logic       done,
    output logic       contact,
    output logic       overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_WAIT,
        S_COMMIT
    } state_t;

    localparam logic [1:0] SLOT_HERO = 2'd0;
    localparam logic [1:0] SLOT_LAST = 2'd2;

    state_t          state_q, state_d;
    logic [1:0]      slot_q, slot_d;
    logic [2:0][3:0] dir_q, dir_d;
    logic [2:0][3:0] pos_x_q, pos_x_d;
    logic [2:0][3:0] pos_y_q, pos_y_d;
    logic [3:0]      tgt_x_q, tgt_x_d;
    logic [3:0]      tgt_y_q, tgt_y_d;
    logic            tgt_valid_q, tgt_valid_d;
    logic [7:0]      map_addr_q, map_addr_d;
    logic            done_q, done_d;
    logic            contact_q, contact_d;
    logic            overrun_q, overrun_d;

    logic [3:0] cur_x, cur_y, cur_dir;
    logic [3:0] step_x, step_y;
    logic       step_valid;
    logic       occupied, hero_occupied, accept;

    // Current mover's position and latched request.
    always_comb begin
        cur_x   = pos_x_q[0];
        cur_y   = pos_y_q[0];
        cur_dir = dir_q[0];
        case (slot_q)
            2'd1: begin
                cur_x   = pos_x_q[1];
                cur_y   = pos_y_q[1];
                cur_dir = dir_q[1];
            end
            2'd2: begin
                cur_x   = pos_x_q[2];
                cur_y   = pos_y_q[2];
                cur_dir = dir_q[2];
            end
            default: ;
        endcase
    end

    // Direction decode with priority up > down > left > right; no wrap-around,
    // so a step off the grid is invalid and the target falls back to the current cell.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, otherwise a latch is inferred.
        step_x     = cur_x;
        step_y     = cur_y;
        step_valid = 1'b0;
        if (cur_dir[3]) begin
            step_y     = cur_y - 4'd1;
            step_valid = (cur_y != 4'd0);
        end else if (cur_dir[2]) begin
            step_y     = cur_y + 4'd1;
            step_valid = (cur_y != 4'd15);
        end else if (cur_dir[1]) begin
            step_x     = cur_x - 4'd1;
            step_valid = (cur_x != 4'd0);
        end else if (cur_dir[0]) begin
            step_x     = cur_x + 4'd1;
            step_valid = (cur_x != 4'd15);
        end
        if (!step_valid) begin
            step_x = cur_x;
            step_y = cur_y;
        end
    end

    // Occupancy uses live positions, so earlier commits in this round are seen.
    always_comb begin
        occupied      = 1'b0;
        hero_occupied = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i != int'(slot_q) && pos_x_q[i] == tgt_x_q && pos_y_q[i] == tgt_y_q) begin
                occupied = 1'b1;
                if (i == 0) hero_occupied = 1'b1;
            end
        end
        accept = tgt_valid_q && !map_wall && !occupied;
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        dir_d       = dir_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        tgt_x_d     = tgt_x_q;
        tgt_y_d     = tgt_y_q;
        tgt_valid_d = tgt_valid_q;
        map_addr_d  = map_addr_q;
        done_d      = 1'b0;
        contact_d   = 1'b0;
        overrun_d   = overrun_q || (tick && state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    dir_d   = {e1_dir, e0_dir, hero_dir};
                    slot_d  = SLOT_HERO;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                tgt_x_d     = step_x;
                tgt_y_d     = step_y;
                tgt_valid_d = step_valid;
                map_addr_d  = {step_y, step_x};
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                for (int i = 0; i < 3; i++) begin
                    if (accept && i == int'(slot_q)) begin
                        pos_x_d[i] = tgt_x_q;
                        pos_y_d[i] = tgt_y_q;
                    end
                end
                contact_d = tgt_valid_q && occupied && (slot_q == SLOT_HERO || hero_occupied);
                if (slot_q == SLOT_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    slot_d  = slot_q + 2'd1;
                    state_d = S_CALC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all state, including the latched directions, is reset; there is no storage array that could be left unreset.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            slot_q      <= 2'd0;
            dir_q       <= '0;
            pos_x_q     <= {E1_X0, E0_X0, HERO_X0};
            pos_y_q     <= {E1_Y0, E0_Y0, HERO_Y0};
            tgt_x_q     <= 4'd0;
            tgt_y_q     <= 4'd0;
            tgt_valid_q <= 1'b0;
            map_addr_q  <= 8'd0;
            done_q      <= 1'b0;
            contact_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q     <= state_d;
            slot_q      <= slot_d;
            dir_q       <= dir_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            tgt_x_q     <= tgt_x_d;
            tgt_y_q     <= tgt_y_d;
            tgt_valid_q <= tgt_valid_d;
            map_addr_q  <= map_addr_d;
            done_q      <= done_d;
            contact_q   <= contact_d;
            overrun_q   <= overrun_d;
        end
    end

    assign map_addr        = map_addr_q;
    assign position_hero_x = pos_x_q[0];
    assign position_hero_y = pos_y_q[0];
    assign e0_x            = pos_x_q[1];
    assign e0_y            = pos_y_q[1];
    assign e1_x            = pos_x_q[2];
    assign e1_y            = pos_y_q[2];
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign contact         = contact_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_move_round_arbiter.sv
// Self-checking bench for move_round_arbiter: a round-level reference model
// predicts per-slot positions, ROM queries and contact pulses.
module tb_move_round_arbiter;

    logic       clk_1 = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] hero_dir, e0_dir, e1_dir;
    logic [7:0] map_addr;
    logic       map_wall = 1'b0;
    logic [3:0] position_hero_x, position_hero_y, e0_x, e0_y, e1_x, e1_y;
    logic       busy, done, contact, overrun;

    int  checks = 0;
    int  errors = 0;
    int  mx[3];
    int  my[3];
    bit  exp_overrun;
    bit  wall_mem [256];

    move_round_arbiter dut (
        .clk_1          (clk_1),
        .rst            (rst),
        .tick           (tick),
        .hero_dir       (hero_dir),
        .e0_dir         (e0_dir),
        .e1_dir         (e1_dir),
        .map_addr       (map_addr),
        .map_wall       (map_wall),
        .position_hero_x(position_hero_x),
        .position_hero_y(position_hero_y),
        .e0_x           (e0_x),
        .e0_y           (e0_y),
        .e1_x           (e1_x),
        .e1_y           (e1_y),
        .busy           (busy),
        .done           (done),
        .contact        (contact),
        .overrun        (overrun)
    );

    always #5 clk_1 = ~clk_1;

    // Registered map ROM: one-cycle read latency.
    always @(posedge clk_1) map_wall <= wall_mem[map_addr];

    function automatic logic [23:0] model_pos();
        return {4'(mx[0]), 4'(my[0]), 4'(mx[1]), 4'(my[1]), 4'(mx[2]), 4'(my[2])};
    endfunction

    function automatic logic [23:0] dut_pos();
        return {position_hero_x, position_hero_y, e0_x, e0_y, e1_x, e1_y};
    endfunction

    task automatic clear_walls();
        for (int a = 0; a < 256; a++) wall_mem[a] = 1'b0;
    endtask

    task automatic model_reset();
        mx[0] = 0;  my[0] = 0;
        mx[1] = 15; my[1] = 15;
        mx[2] = 15; my[2] = 0;
        exp_overrun = 1'b0;
    endtask

    // Called at a negedge. Plays one full round and checks every cycle up to the done cycle.
    task automatic play_round(input string tag, input logic [3:0] hd, input logic [3:0] ed0,
                              input logic [3:0] ed1, input int extra_tick_at, input bit scramble);
        logic [3:0]  d[3];
        logic [23:0] pre, snap[3], exp_pos;
        logic [7:0]  ea[3];
        bit          ec[3];
        bit          exp_contact;
        d[0] = hd; d[1] = ed0; d[2] = ed1;
        pre = model_pos();
        for (int i = 0; i < 3; i++) begin
            int dx, dy, nx, ny;
            bit valid, occ, hocc, wall;
            dx = 0; dy = 0;
            if (d[i][3]) dy = -1;
            else if (d[i][2]) dy = 1;
            else if (d[i][1]) dx = -1;
            else if (d[i][0]) dx = 1;
            nx = mx[i] + dx;
            ny = my[i] + dy;
            valid = (d[i] != 4'd0) && nx >= 0 && nx <= 15 && ny >= 0 && ny <= 15;
            ea[i] = valid ? 8'(ny * 16 + nx) : 8'(my[i] * 16 + mx[i]);
            occ = 1'b0; hocc = 1'b0;
            for (int j = 0; j < 3; j++) begin
                if (j != i && mx[j] == nx && my[j] == ny) begin
                    occ = 1'b1;
                    if (j == 0) hocc = 1'b1;
                end
            end
            ec[i] = valid && occ && (i == 0 || hocc);
            wall = 1'b0;
            if (valid) wall = wall_mem[ny * 16 + nx];
            if (valid && !wall && !occ) begin
                mx[i] = nx;
                my[i] = ny;
            end
            snap[i] = model_pos();
        end

        hero_dir = hd; e0_dir = ed0; e1_dir = ed1;
        tick = 1'b1;
        @(posedge clk_1);
        @(negedge clk_1);
        tick = 1'b0;
        if (scramble) begin
            hero_dir = 4'($urandom); e0_dir = 4'($urandom); e1_dir = 4'($urandom);
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || contact !== 1'b0 || dut_pos() !== pre) begin
            errors++;
            $display("FAIL %s start: busy/done/contact/pos actual=%b%b%b %h required=100 %h",
                     tag, busy, done, contact, dut_pos(), pre);
        end
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk_1);
            @(negedge clk_1);
            tick = (k == extra_tick_at);
            if (k == extra_tick_at && k <= 8) exp_overrun = 1'b1;
            if (scramble) begin
                hero_dir = 4'($urandom); e0_dir = 4'($urandom); e1_dir = 4'($urandom);
            end
            exp_pos = (k < 3) ? pre : (k < 6) ? snap[0] : (k < 9) ? snap[1] : snap[2];
            exp_contact = (k == 3 && ec[0]) || (k == 6 && ec[1]) || (k == 9 && ec[2]);
            checks++;
            if (dut_pos() !== exp_pos) begin
                errors++;
                $display("FAIL %s pos k=%0d actual=%h required=%h", tag, k, dut_pos(), exp_pos);
            end
            checks++;
            if (busy !== (k < 9) || done !== (k == 9)) begin
                errors++;
                $display("FAIL %s busy/done k=%0d actual=%b%b required=%b%b",
                         tag, k, busy, done, k < 9, k == 9);
            end
            checks++;
            if (contact !== exp_contact) begin
                errors++;
                $display("FAIL %s contact k=%0d actual=%b required=%b", tag, k, contact, exp_contact);
            end
            if (k == 1 || k == 4 || k == 7) begin
                checks++;
                if (map_addr !== ea[(k - 1) / 3]) begin
                    errors++;
                    $display("FAIL %s map_addr k=%0d actual=%h required=%h",
                             tag, k, map_addr, ea[(k - 1) / 3]);
                end
            end
        end
        tick = 1'b0;
        checks++;
        if (overrun !== exp_overrun) begin
            errors++;
            $display("FAIL %s overrun actual=%b required=%b", tag, overrun, exp_overrun);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_1);
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_pos() !== model_pos() || busy !== 1'b0 || done !== 1'b0 || contact !== 1'b0
            || overrun !== 1'b0 || map_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset: pos=%h busy=%b done=%b contact=%b overrun=%b addr=%h required pos=%h rest 0",
                     dut_pos(), busy, done, contact, overrun, map_addr, model_pos());
        end
        @(negedge clk_1);
        rst = 1'b0;
    endtask

    task automatic test_priority_boundary();
        wall_mem[0] = 1'b1;
        play_round("prio", 4'b1010, 4'b0000, 4'b0000, 0, 1'b0);
        wall_mem[0] = 1'b0;
        checks++;
        if (position_hero_x !== 4'd0 || position_hero_y !== 4'd0) begin
            errors++;
            $display("FAIL prio hero actual=(%0d,%0d) required=(0,0)", position_hero_x, position_hero_y);
        end
        repeat (2) @(negedge clk_1);
    endtask

    task automatic test_wall();
        wall_mem[8'h10] = 1'b1;
        play_round("wall", 4'b0100, 4'b0000, 4'b0000, 0, 1'b0);
        wall_mem[8'h10] = 1'b0;
        checks++;
        if (position_hero_x !== 4'd0 || position_hero_y !== 4'd0) begin
            errors++;
            $display("FAIL wall hero actual=(%0d,%0d) required=(0,0)", position_hero_x, position_hero_y);
        end
        repeat (2) @(negedge clk_1);
    endtask

    task automatic test_basic_move();
        play_round("basic", 4'b0001, 4'b0000, 4'b0000, 0, 1'b0);
        checks++;
        if (position_hero_x !== 4'd1 || position_hero_y !== 4'd0) begin
            errors++;
            $display("FAIL basic hero actual=(%0d,%0d) required=(1,0)", position_hero_x, position_hero_y);
        end
        repeat (2) @(negedge clk_1);
    endtask

    task automatic test_mid_round_reset();
        hero_dir = 4'b0001; e0_dir = 4'b0000; e1_dir = 4'b0000;
        tick = 1'b1;
        @(posedge clk_1);
        @(negedge clk_1);
        tick = 1'b0;
        repeat (4) @(posedge clk_1);
        @(negedge clk_1);
        checks++;
        if (position_hero_x !== 4'd2 || position_hero_y !== 4'd0) begin
            errors++;
            $display("FAIL midrst pre hero actual=(%0d,%0d) required=(2,0)", position_hero_x, position_hero_y);
        end
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_pos() !== model_pos() || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst async pos=%h busy=%b required pos=%h busy=0", dut_pos(), busy, model_pos());
        end
        @(negedge clk_1);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_1);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst idle c=%0d done=%b busy=%b required 0 0", c, done, busy);
            end
        end
    endtask

    task automatic test_collision();
        test_reset();
        for (int r = 0; r < 18; r++) begin
            logic [3:0] hd, ed;
            hd = (r < 5) ? 4'b0001 : (r < 10) ? 4'b0100 : 4'b0000;
            ed = (r < 8) ? 4'b0010 : 4'b1000;
            play_round("approach", hd, ed, 4'b0000, 0, 1'b0);
        end
        play_round("collide", 4'b0001, 4'b0010, 4'b0000, 0, 1'b0);
        checks++;
        if (dut_pos() !== {4'd6, 4'd5, 4'd7, 4'd5, 4'd15, 4'd0}) begin
            errors++;
            $display("FAIL collide final actual=%h required=%h", dut_pos(), 24'h6575f0);
        end
        repeat (2) @(negedge clk_1);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++)
            play_round("b2b", 4'($urandom), 4'($urandom), 4'($urandom), 0, 1'b0);
        repeat (2) @(negedge clk_1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            for (int a = 0; a < 256; a++) wall_mem[a] = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 3; i++) wall_mem[my[i] * 16 + mx[i]] = 1'b0;
            play_round("random", 4'($urandom), 4'($urandom), 4'($urandom), 0, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk_1);
        end
        clear_walls();
        repeat (2) @(negedge clk_1);
    endtask

    task automatic test_overrun();
        play_round("overrun", 4'b0001, 4'b0000, 4'b0000, 3, 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_1);
            checks++;
            if (busy !== 1'b0 || overrun !== 1'b1) begin
                errors++;
                $display("FAIL overrun idle c=%0d busy=%b overrun=%b required 0 1", c, busy, overrun);
            end
        end
        play_round("overrun_hold", 4'b0000, 4'b0000, 4'b0000, 0, 1'b0);
        repeat (2) @(negedge clk_1);
        test_reset();
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        hero_dir = 4'd0; e0_dir = 4'd0; e1_dir = 4'd0;
        clear_walls();
        model_reset();
        repeat (2) @(negedge clk_1);
        test_reset();
        test_priority_boundary();
        test_wall();
        test_basic_move();
        test_mid_round_reset();
        test_collision();
        test_back_to_back();
        test_random();
        test_overrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
